// File: rtl/convertidor_bcd_binario_4_digitos_if.sv
// Handshake and data bundle for the BCD-to-binary converter.
// Optional error_bcd signal exists only when CONV_BCD_VALIDACION_EN is defined.
interface convertidor_bcd_binario_4_digitos_if #(
  parameter int NUM_DIGITOS = 4,
  parameter int ANCHO_BIN   = 14
);
  logic                     inicio;
  logic [4*NUM_DIGITOS-1:0] bcd_entrada;
  logic [ANCHO_BIN-1:0]     dato_binario;
  logic                     ocupado;
  logic                     listo;
`ifdef CONV_BCD_VALIDACION_EN
  logic                     error_bcd;
`endif

  modport master (
    output inicio, bcd_entrada,
    input  dato_binario, ocupado, listo
`ifdef CONV_BCD_VALIDACION_EN
    , input error_bcd
`endif
  );

  modport slave (
    input  inicio, bcd_entrada,
    output dato_binario, ocupado, listo
`ifdef CONV_BCD_VALIDACION_EN
    , output error_bcd
`endif
  );
endinterface

// File: rtl/convertidor_bcd_binario_4_digitos.sv
// Sequential BCD-to-binary converter (reverse double dabble, one iteration per clock).
// Define CONV_BCD_VALIDACION_EN to flag digits above 9 through error_bcd.
//
// state      | meaning
// REPOSO     | idle, waiting for inicio; loads operands on accept
// CONVIERTE  | one shift-right/subtract-3 iteration per clock, ANCHO_BIN total
module convertidor_bcd_binario_4_digitos #(
  parameter int NUM_DIGITOS = 4,
  parameter int ANCHO_BIN   = 14
) (
  input  logic clk,
  input  logic reset,
  convertidor_bcd_binario_4_digitos_if.slave bus
);
  localparam int ANCHO_BCD = 4 * NUM_DIGITOS;
  localparam int ANCHO_CNT = (ANCHO_BIN > 2) ? $clog2(ANCHO_BIN) : 1;
  localparam logic [ANCHO_CNT-1:0] CNT_ULTIMO = ANCHO_CNT'(ANCHO_BIN - 1);

  typedef enum logic {REPOSO, CONVIERTE} estado_t;

  estado_t              estado_q, estado_d;
  logic [ANCHO_BCD-1:0] reg_bcd_q, reg_bcd_d;
  logic [ANCHO_BIN-1:0] reg_bin_q, reg_bin_d;
  logic [ANCHO_CNT-1:0] cnt_q, cnt_d;
  logic [ANCHO_BIN-1:0] dato_q, dato_d;
  logic                 listo_q, listo_d;
  logic                 ocupado_q, ocupado_d;

  logic [ANCHO_BCD-1:0] bcd_sh, bcd_corr;
  logic [ANCHO_BIN-1:0] bin_sh;
  logic                 ultimo;
  logic                 acepta;

`ifdef CONV_BCD_VALIDACION_EN
  logic invalido_q, invalido_d;
  logic error_q, error_d;
  logic digito_invalido;

  always_comb begin
    digito_invalido = 1'b0;
    for (int i = 0; i < NUM_DIGITOS; i++) begin
      if (bus.bcd_entrada[4*i +: 4] > 4'd9) digito_invalido = 1'b1;
    end
  end
`endif

  assign ultimo = (cnt_q == CNT_ULTIMO);
  assign acepta = (estado_q == REPOSO) && bus.inicio;

  // One iteration: shift the joint register right, then pull each digit >= 8 down by 3.
  always_comb begin
    {bcd_sh, bin_sh} = {reg_bcd_q, reg_bin_q} >> 1;
    bcd_corr = bcd_sh;
    for (int i = 0; i < NUM_DIGITOS; i++) begin
      if (bcd_sh[4*i+3]) bcd_corr[4*i +: 4] = bcd_sh[4*i +: 4] - 4'd3;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado_q   <= REPOSO;
      reg_bcd_q  <= '0;
      reg_bin_q  <= '0;
      cnt_q      <= '0;
      dato_q     <= '0;
      listo_q    <= 1'b0;
      ocupado_q  <= 1'b0;
`ifdef CONV_BCD_VALIDACION_EN
      invalido_q <= 1'b0;
      error_q    <= 1'b0;
`endif
    end else begin
      estado_q   <= estado_d;
      reg_bcd_q  <= reg_bcd_d;
      reg_bin_q  <= reg_bin_d;
      cnt_q      <= cnt_d;
      dato_q     <= dato_d;
      listo_q    <= listo_d;
      ocupado_q  <= ocupado_d;
`ifdef CONV_BCD_VALIDACION_EN
      invalido_q <= invalido_d;
      error_q    <= error_d;
`endif
    end
  end

  always_comb begin
    estado_d = estado_q;
    case (estado_q)
      REPOSO:    if (bus.inicio) estado_d = CONVIERTE;
      CONVIERTE: if (ultimo)     estado_d = REPOSO;
      default:                   estado_d = REPOSO;
    endcase
  end

  always_comb begin
    reg_bcd_d  = reg_bcd_q;
    reg_bin_d  = reg_bin_q;
    cnt_d      = cnt_q;
    dato_d     = dato_q;
    listo_d    = 1'b0;
    ocupado_d  = ocupado_q;
`ifdef CONV_BCD_VALIDACION_EN
    invalido_d = invalido_q;
    error_d    = error_q;
`endif
    if (acepta) begin
      reg_bcd_d  = bus.bcd_entrada;
      reg_bin_d  = '0;
      cnt_d      = '0;
      ocupado_d  = 1'b1;
`ifdef CONV_BCD_VALIDACION_EN
      invalido_d = digito_invalido;
      error_d    = 1'b0;
`endif
    end else if (estado_q == CONVIERTE) begin
      reg_bcd_d = bcd_corr;
      reg_bin_d = bin_sh;
      cnt_d     = cnt_q + ANCHO_CNT'(1);
      if (ultimo) begin
        dato_d    = bin_sh;
        listo_d   = 1'b1;
        ocupado_d = 1'b0;
`ifdef CONV_BCD_VALIDACION_EN
        // Invalid input still takes full latency; result is forced to zero.
        if (invalido_q) dato_d = '0;
        error_d = invalido_q;
`endif
      end
    end
  end

  assign bus.dato_binario = dato_q;
  assign bus.listo        = listo_q;
  assign bus.ocupado      = ocupado_q;
`ifdef CONV_BCD_VALIDACION_EN
  assign bus.error_bcd    = error_q;
`endif

endmodule

// File: tb/tb_convertidor_bcd_binario_4_digitos.sv
// Self-checking bench for the BCD-to-binary converter, randomized against a decimal model.
// Validation scenarios are exercised only when CONV_BCD_VALIDACION_EN is defined.
module tb_convertidor_bcd_binario_4_digitos;
  logic clk = 1'b0;
  logic reset;
  int checks = 0;
  int errors = 0;

  convertidor_bcd_binario_4_digitos_if #(.NUM_DIGITOS(4), .ANCHO_BIN(14)) bus_if ();

  convertidor_bcd_binario_4_digitos #(.NUM_DIGITOS(4), .ANCHO_BIN(14)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if.slave)
  );

  always #5 clk = ~clk;

  // Results of the last run_conv call
  int          r_lat;
  logic [13:0] r_res;
  logic        r_ocup_start, r_ocup_end, r_overlap, r_hold_bad, r_listo_after;
  logic        r_err, r_err_at_accept, r_err_before;

  function automatic int modelo(input logic [15:0] bcd);
    return 1000 * int'(bcd[15:12]) + 100 * int'(bcd[11:8]) + 10 * int'(bcd[7:4]) + int'(bcd[3:0]);
  endfunction

  task automatic run_conv(input logic [15:0] bcd);
    logic [13:0] prev;
    @(negedge clk);
`ifdef CONV_BCD_VALIDACION_EN
    r_err_before = bus_if.error_bcd;
`endif
    bus_if.bcd_entrada = bcd;
    bus_if.inicio = 1'b1;
    prev = bus_if.dato_binario;
    @(posedge clk);
    @(negedge clk);
    bus_if.inicio = 1'b0;
    r_ocup_start = bus_if.ocupado;
`ifdef CONV_BCD_VALIDACION_EN
    r_err_at_accept = bus_if.error_bcd;
`endif
    r_lat = -1; r_overlap = 1'b0; r_hold_bad = 1'b0; r_res = '0; r_ocup_end = 1'b1; r_err = 1'b0;
    for (int n = 1; n <= 30 && r_lat < 0; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus_if.listo && bus_if.ocupado) r_overlap = 1'b1;
      if (bus_if.listo) begin
        r_lat = n;
        r_res = bus_if.dato_binario;
        r_ocup_end = bus_if.ocupado;
`ifdef CONV_BCD_VALIDACION_EN
        r_err = bus_if.error_bcd;
`endif
      end else if (bus_if.dato_binario !== prev) begin
        r_hold_bad = 1'b1;
      end
    end
    @(posedge clk);
    @(negedge clk);
    r_listo_after = bus_if.listo;
  endtask

  task automatic check_conv(input string name, input logic [15:0] bcd, input int exp_val);
    checks++;
    if (r_lat !== 14) begin
      errors++; $display("FAIL %s latency: got %0d expected 14", name, r_lat);
    end
    checks++;
    if (r_res !== 14'(exp_val)) begin
      errors++; $display("FAIL %s result for %h: got %0d expected %0d", name, bcd, r_res, exp_val);
    end
    checks++;
    if (r_ocup_start !== 1'b1 || r_ocup_end !== 1'b0 || r_overlap !== 1'b0) begin
      errors++; $display("FAIL %s ocupado: start %b end %b overlap %b expected 1 0 0", name, r_ocup_start, r_ocup_end, r_overlap);
    end
    checks++;
    if (r_listo_after !== 1'b0 || r_hold_bad !== 1'b0) begin
      errors++; $display("FAIL %s listo width/hold: listo_after %b hold_bad %b expected 0 0", name, r_listo_after, r_hold_bad);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus_if.inicio = 1'b0;
    bus_if.bcd_entrada = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus_if.dato_binario !== 14'd0 || bus_if.listo !== 1'b0 || bus_if.ocupado !== 1'b0) begin
      errors++; $display("FAIL reset outputs: dato %h listo %b ocupado %b expected 0 0 0", bus_if.dato_binario, bus_if.listo, bus_if.ocupado);
    end
`ifdef CONV_BCD_VALIDACION_EN
    checks++;
    if (bus_if.error_bcd !== 1'b0) begin
      errors++; $display("FAIL reset error_bcd: got %b expected 0", bus_if.error_bcd);
    end
`endif
    reset = 1'b0;
  endtask

  task automatic test_directed();
    logic [15:0] v [4] = '{16'h9999, 16'h1234, 16'h0000, 16'h0009};
    foreach (v[i]) begin
      run_conv(v[i]);
      check_conv("directed", v[i], modelo(v[i]));
    end
  endtask

  task automatic test_random();
    logic [15:0] bcd;
    for (int k = 0; k < 10; k++) begin
      bcd = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      run_conv(bcd);
      check_conv("random", bcd, modelo(bcd));
`ifdef CONV_BCD_VALIDACION_EN
      checks++;
      if (r_err !== 1'b0) begin
        errors++; $display("FAIL random error_bcd for %h: got %b expected 0", bcd, r_err);
      end
`endif
    end
  endtask

  task automatic test_ignore_inicio();
    int pulses = 0;
    int lat = -1;
    logic [13:0] res = '0;
    @(negedge clk);
    bus_if.bcd_entrada = 16'h0500;
    bus_if.inicio = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (n <= 10) begin
        bus_if.inicio = ~bus_if.inicio;
        bus_if.bcd_entrada = 16'h7777;
      end else begin
        bus_if.inicio = 1'b0;
      end
      if (bus_if.listo) begin
        pulses++;
        if (lat < 0) begin lat = n - 1; res = bus_if.dato_binario; end
      end
      @(posedge clk);
    end
    @(negedge clk);
    checks++;
    if (pulses !== 1 || lat !== 14) begin
      errors++; $display("FAIL ignore_inicio pulses/latency: got %0d/%0d expected 1/14", pulses, lat);
    end
    checks++;
    if (res !== 14'd500) begin
      errors++; $display("FAIL ignore_inicio result: got %0d expected 500", res);
    end
    checks++;
    if (bus_if.ocupado !== 1'b0) begin
      errors++; $display("FAIL ignore_inicio idle: ocupado %b expected 0", bus_if.ocupado);
    end
  endtask

  task automatic test_reset_mid();
    int late_listo = 0;
    @(negedge clk);
    bus_if.bcd_entrada = 16'h4321;
    bus_if.inicio = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus_if.inicio = 1'b0;
    repeat (7) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (bus_if.dato_binario !== 14'd0 || bus_if.listo !== 1'b0 || bus_if.ocupado !== 1'b0) begin
      errors++; $display("FAIL reset_mid outputs: dato %h listo %b ocupado %b expected 0 0 0", bus_if.dato_binario, bus_if.listo, bus_if.ocupado);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (bus_if.listo || bus_if.ocupado) late_listo++;
    end
    checks++;
    if (late_listo !== 0) begin
      errors++; $display("FAIL reset_mid activity after abort: got %0d cycles expected 0", late_listo);
    end
    run_conv(16'h0042);
    check_conv("after_reset", 16'h0042, 42);
  endtask

  task automatic test_back_to_back();
    int times [$];
    int cyc = 0;
    int overlap = 0;
    int bad_val = 0;
    @(negedge clk);
    bus_if.bcd_entrada = 16'h0100;
    bus_if.inicio = 1'b1;
    while (times.size() < 3 && cyc < 80) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (bus_if.listo && bus_if.ocupado) overlap++;
      if (bus_if.listo) begin
        times.push_back(cyc);
        if (bus_if.dato_binario !== 14'd100) bad_val++;
      end
    end
    bus_if.inicio = 1'b0;
    checks++;
    if (times.size() !== 3) begin
      errors++; $display("FAIL back_to_back pulses: got %0d expected 3", times.size());
    end else begin
      checks++;
      if (times[0] !== 15 || times[1] - times[0] !== 15 || times[2] - times[1] !== 15) begin
        errors++; $display("FAIL back_to_back spacing: got %0d %0d %0d expected 15 30 45", times[0], times[1], times[2]);
      end
    end
    checks++;
    if (overlap !== 0 || bad_val !== 0) begin
      errors++; $display("FAIL back_to_back overlap/value: got %0d/%0d expected 0/0", overlap, bad_val);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (bus_if.ocupado !== 1'b0) begin
      errors++; $display("FAIL back_to_back stop: ocupado %b expected 0", bus_if.ocupado);
    end
  endtask

`ifdef CONV_BCD_VALIDACION_EN
  task automatic test_validacion();
    run_conv(16'h12A4);
    checks++;
    if (r_lat !== 14 || r_res !== 14'd0 || r_err !== 1'b1) begin
      errors++; $display("FAIL validacion invalid: lat %0d dato %0d err %b expected 14 0 1", r_lat, r_res, r_err);
    end
    run_conv(16'h0001);
    checks++;
    if (r_err_before !== 1'b1 || r_err_at_accept !== 1'b0) begin
      errors++; $display("FAIL validacion clear: before %b at_accept %b expected 1 0", r_err_before, r_err_at_accept);
    end
    checks++;
    if (r_res !== 14'd1 || r_err !== 1'b0) begin
      errors++; $display("FAIL validacion recovery: dato %0d err %b expected 1 0", r_res, r_err);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_ignore_inicio();
    test_reset_mid();
    test_back_to_back();
`ifdef CONV_BCD_VALIDACION_EN
    test_validacion();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
